// File: rtl/kc_ls1u_imem_arbiter.sv
// Shares the KC_LS1u instruction memory between CPU fetch (priority) and debug (starvation-guarded); rsp_v 2 cycles after accept, one fetch in flight.
// A held response blocks new accepts. Define IMEM_OOR_TRAP_EN to flag and zero fetches at or beyond ROM_DEPTH.
module kc_ls1u_imem_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 8,
  parameter int ROM_DEPTH  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_v,
  output logic              cpu_req_rdy,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rsp_v,
  input  logic              cpu_rsp_rdy,
  output logic [DATA_W-1:0] cpu_instr,
  input  logic              dbg_req_v,
  output logic              dbg_req_rdy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_rsp_v,
  input  logic              dbg_rsp_rdy,
  output logic [DATA_W-1:0] dbg_instr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_instr,
  output logic              oor_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam int            CW  = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  if (STARVE_LIM < 1 || ROM_DEPTH < 1) begin : g_bad_param
    $error("kc_ls1u_imem_arbiter: STARVE_LIM and ROM_DEPTH must be >= 1");
  end

  logic [1:0]        state;
  logic              owner_dbg;
  logic [CW-1:0]     starve_cnt;
  logic              dbg_starved;
  logic              cpu_grant;
  logic              dbg_grant;
  logic              accept;
  logic              rsp_done;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] fetch_data;

  // Debug only overrides the CPU once it has lost STARVE_LIM arbitrations in a row.
  assign dbg_starved = dbg_req_v && (starve_cnt == LIM);
  assign cpu_grant   = cpu_req_v && !dbg_starved;
  assign dbg_grant   = dbg_req_v && !cpu_grant;

  assign cpu_req_rdy = !rst && (state == S_IDLE) && cpu_grant;
  assign dbg_req_rdy = !rst && (state == S_IDLE) && dbg_grant;
  assign accept      = cpu_req_rdy || dbg_req_rdy;
  assign acc_addr    = dbg_req_rdy ? dbg_addr : cpu_addr;

  assign rsp_done = owner_dbg ? (dbg_rsp_v && dbg_rsp_rdy) : (cpu_rsp_v && cpu_rsp_rdy);

`ifdef IMEM_OOR_TRAP_EN
  logic oor_pend;
  logic oor_flag;
  logic acc_oor;

  assign acc_oor = ({1'b0, acc_addr} >= (ADDR_W + 1)'(ROM_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_pend <= 1'b0;
      oor_flag <= 1'b0;
    end else if (accept) begin
      oor_pend <= acc_oor;
      if (acc_oor) oor_flag <= 1'b1;
    end
  end

  assign fetch_data = oor_pend ? '0 : mem_instr;
  assign oor_err    = oor_flag;
`else
  assign fetch_data = mem_instr;
  assign oor_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner_dbg  <= 1'b0;
      mem_addr   <= '0;
      cpu_rsp_v  <= 1'b0;
      cpu_instr  <= '0;
      dbg_rsp_v  <= 1'b0;
      dbg_instr  <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner_dbg <= dbg_req_rdy;
            mem_addr  <= acc_addr;
            state     <= S_FETCH;
          end
          if (dbg_req_rdy) begin
            starve_cnt <= '0;
          end else if (cpu_req_rdy && dbg_req_v && (starve_cnt != LIM)) begin
            starve_cnt <= starve_cnt + CW'(1);
          end
        end
        S_FETCH: begin
          if (owner_dbg) begin
            dbg_instr <= fetch_data;
            dbg_rsp_v <= 1'b1;
          end else begin
            cpu_instr <= fetch_data;
            cpu_rsp_v <= 1'b1;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_done) begin
            if (owner_dbg) dbg_rsp_v <= 1'b0;
            else           cpu_rsp_v <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kc_ls1u_imem_arbiter.sv
// Bench for kc_ls1u_imem_arbiter: vector table, scoreboard on responses, hand sequences for starvation, backpressure, reset and range trap.
module tb_kc_ls1u_imem_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RD = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_v, cpu_req_rdy, cpu_rsp_v, cpu_rsp_rdy;
  logic          dbg_req_v, dbg_req_rdy, dbg_rsp_v, dbg_rsp_rdy;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_instr, dbg_instr, mem_instr;
  logic          oor_err;

  kc_ls1u_imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(8), .ROM_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_v(cpu_req_v), .cpu_req_rdy(cpu_req_rdy), .cpu_addr(cpu_addr),
    .cpu_rsp_v(cpu_rsp_v), .cpu_rsp_rdy(cpu_rsp_rdy), .cpu_instr(cpu_instr),
    .dbg_req_v(dbg_req_v), .dbg_req_rdy(dbg_req_rdy), .dbg_addr(dbg_addr),
    .dbg_rsp_v(dbg_rsp_v), .dbg_rsp_rdy(dbg_rsp_rdy), .dbg_instr(dbg_instr),
    .mem_addr(mem_addr), .mem_instr(mem_instr), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Instruction memory model: 26 mapped words, zero elsewhere.
  logic [DW-1:0] rom [0:RD-1];

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    if (a < AW'(RD)) return rom[a[4:0]];
    return '0;
  endfunction

  assign mem_instr = rom_f(mem_addr);

  typedef struct {
    logic          dbg;
    logic [DW-1:0] instr;
    int            acc;
  } sb_t;

  sb_t  sbq[$];
  logic glog[$];
  int   alog[$];
  logic pc = 1'b0;
  logic pd = 1'b0;

  always @(posedge rst) sbq.delete();

  task automatic sb_push(input logic is_dbg, input logic [AW-1:0] a);
    sb_t e;
    e.dbg = is_dbg;
    e.instr = rom_f(a);
    e.acc = cyc;
    sbq.push_back(e);
    glog.push_back(is_dbg);
    alog.push_back(cyc);
  endtask

  task automatic sb_rise(input logic is_dbg);
    if (sbq.size() == 0) begin
      check("sb_spurious_rsp", 32'(is_dbg), 32'hFFFF_FFFF);
    end else begin
      check("sb_rsp_owner", 32'(is_dbg), 32'(sbq[0].dbg));
      check("sb_rsp_latency", 32'(cyc - sbq[0].acc), 32'd2);
    end
  endtask

  task automatic sb_pop(input logic [DW-1:0] got);
    sb_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("sb_instr", 32'(got), 32'(e.instr));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_req_v && cpu_req_rdy) sb_push(1'b0, cpu_addr);
      if (dbg_req_v && dbg_req_rdy) sb_push(1'b1, dbg_addr);
      if (cpu_rsp_v && !pc) sb_rise(1'b0);
      if (dbg_rsp_v && !pd) sb_rise(1'b1);
      if (cpu_rsp_v && cpu_rsp_rdy) sb_pop(cpu_instr);
      if (dbg_rsp_v && dbg_rsp_rdy) sb_pop(dbg_instr);
    end
    pc = cpu_rsp_v;
    pd = dbg_rsp_v;
  end

  typedef struct {
    logic          cv;
    logic [AW-1:0] ca;
    logic          dv;
    logic [AW-1:0] da;
    logic          exp_dbg;
    logic [DW-1:0] exp_instr;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    @(posedge clk); #1;
    cpu_req_v = v.cv; cpu_addr = v.ca; dbg_req_v = v.dv; dbg_addr = v.da;
    n = 0;
    @(negedge clk); #1;
    while (!(cpu_req_rdy || dbg_req_rdy) && n < 10) begin @(negedge clk); #1; n++; end
    check({nm, "_accept"}, 32'(cpu_req_rdy || dbg_req_rdy), 32'd1);
    check({nm, "_grant_dbg"}, 32'(dbg_req_rdy), 32'(v.exp_dbg));
    @(posedge clk); #1;
    cpu_req_v = 1'b0; dbg_req_v = 1'b0;
    n = 0;
    @(negedge clk); #1;
    while (!(cpu_rsp_v || dbg_rsp_v) && n < 10) begin @(negedge clk); #1; n++; end
    check({nm, "_dbg_rsp_v"}, 32'(dbg_rsp_v), 32'(v.exp_dbg));
    check({nm, "_cpu_rsp_v"}, 32'(cpu_rsp_v), 32'(!v.exp_dbg));
    check({nm, "_instr"}, 32'(v.exp_dbg ? dbg_instr : cpu_instr), 32'(v.exp_instr));
    @(posedge clk); #1;
  endtask

  task automatic wait_neg(input string nm, input int which);
    // which: 0 cpu_req_rdy, 1 dbg_req_rdy, 2 cpu_rsp_v, 3 dbg_rsp_v
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      @(negedge clk); #1;
      case (which)
        0: hit = cpu_req_rdy;
        1: hit = dbg_req_rdy;
        2: hit = cpu_rsp_v;
        default: hit = dbg_rsp_v;
      endcase
      n++;
    end
    check({nm, "_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < RD; i++) rom[i] = 16'h4000 + 16'(i);
    rom[0] = 16'h3101; rom[6] = 16'h1100; rom[10] = 16'h0DFF; rom[25] = 16'h08FF;

    vecs[0] = '{1'b1, 24'd0,        1'b0, 24'd0,  1'b0, 16'h3101};
    vecs[1] = '{1'b0, 24'd0,        1'b1, 24'd10, 1'b1, 16'h0DFF};
    vecs[2] = '{1'b1, 24'd25,       1'b1, 24'd6,  1'b0, 16'h08FF};
    vecs[3] = '{1'b1, 24'd26,       1'b0, 24'd0,  1'b0, 16'h0000};
    vecs[4] = '{1'b1, 24'h800000,   1'b0, 24'd0,  1'b0, 16'h0000};
    vecs[5] = '{1'b0, 24'd0,        1'b1, 24'd6,  1'b1, 16'h1100};

    rst = 1'b1;
    cpu_req_v = 1'b1; dbg_req_v = 1'b1; cpu_addr = 24'd3; dbg_addr = 24'd4;
    cpu_rsp_rdy = 1'b1; dbg_rsp_rdy = 1'b1;
    #12;
    check("rst_cpu_req_rdy", 32'(cpu_req_rdy), 32'd0);
    check("rst_dbg_req_rdy", 32'(dbg_req_rdy), 32'd0);
    check("rst_cpu_rsp_v", 32'(cpu_rsp_v), 32'd0);
    check("rst_dbg_rsp_v", 32'(dbg_rsp_v), 32'd0);
    check("rst_cpu_instr", 32'(cpu_instr), 32'd0);
    check("rst_dbg_instr", 32'(dbg_instr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_oor_err", 32'(oor_err), 32'd0);
    cpu_req_v = 1'b0; dbg_req_v = 1'b0;
    @(negedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Starvation guard: both request continuously.
    glog.delete(); alog.delete();
    @(posedge clk); #1;
    cpu_req_v = 1'b1; cpu_addr = 24'd0; dbg_req_v = 1'b1; dbg_addr = 24'd6;
    for (int n = 0; n < 200 && glog.size() < 18; n++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    cpu_req_v = 1'b0; dbg_req_v = 1'b0;
    repeat (4) @(posedge clk);
    check("starve_grant_count", 32'(glog.size()), 32'd18);
    for (int i = 0; i < glog.size(); i++) begin
      check($sformatf("starve_grant%0d", i), 32'(glog[i]), 32'((i == 8) || (i == 17)));
      if (i > 0) check($sformatf("starve_gap%0d", i), 32'(alog[i] - alog[i-1]), 32'd3);
    end

    // Response backpressure on the CPU side with debug waiting.
    @(posedge clk); #1;
    cpu_rsp_rdy = 1'b0;
    cpu_req_v = 1'b1; cpu_addr = 24'd0; dbg_req_v = 1'b1; dbg_addr = 24'd10;
    wait_neg("bp_cpu_acc", 0);
    @(posedge clk); #1 cpu_req_v = 1'b0;
    wait_neg("bp_cpu_rsp", 2);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_v%0d", k), 32'(cpu_rsp_v), 32'd1);
      check($sformatf("bp_hold_instr%0d", k), 32'(cpu_instr), 32'h3101);
      check($sformatf("bp_no_acc%0d", k), 32'(dbg_req_rdy), 32'd0);
      @(negedge clk); #1;
    end
    @(posedge clk); #1 cpu_rsp_rdy = 1'b1;
    wait_neg("bp_dbg_acc", 1);
    @(posedge clk); #1 dbg_req_v = 1'b0;
    wait_neg("bp_dbg_rsp", 3);
    check("bp_dbg_instr", 32'(dbg_instr), 32'h0DFF);
    repeat (2) @(posedge clk);

    // Reset while the fetch is in flight.
    @(posedge clk); #1 cpu_req_v = 1'b1; cpu_addr = 24'd5;
    wait_neg("rm_acc", 0);
    @(posedge clk); #1 cpu_req_v = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    #1;
    check("rm_cpu_rsp_v", 32'(cpu_rsp_v), 32'd0);
    check("rm_cpu_instr", 32'(cpu_instr), 32'd0);
    check("rm_dbg_instr", 32'(dbg_instr), 32'd0);
    check("rm_mem_addr", 32'(mem_addr), 32'd0);
    cpu_req_v = 1'b1; #1;
    check("rm_rdy_in_rst", 32'(cpu_req_rdy), 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    #1 check("rm_idle_rdy", 32'(cpu_req_rdy), 32'd1);
    cpu_req_v = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check($sformatf("rm_no_rsp%0d", k), 32'(cpu_rsp_v | dbg_rsp_v), 32'd0);
    end

`ifdef IMEM_OOR_TRAP_EN
    check("oor_clear", 32'(oor_err), 32'd0);
    run_vec('{1'b1, 24'd25, 1'b0, 24'd0, 1'b0, 16'h08FF}, "oor25");
    check("oor_after25", 32'(oor_err), 32'd0);
    run_vec('{1'b1, 24'd26, 1'b0, 24'd0, 1'b0, 16'h0000}, "oor26");
    check("oor_after26", 32'(oor_err), 32'd1);
    run_vec('{1'b0, 24'd0, 1'b1, 24'd0, 1'b1, 16'h3101}, "oor_sticky");
    check("oor_sticky", 32'(oor_err), 32'd1);
`else
    run_vec('{1'b1, 24'd26, 1'b0, 24'd0, 1'b0, 16'h0000}, "noor26");
    check("noor_err", 32'(oor_err), 32'd0);
`endif

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
